// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and constants for the multicycle MIPS controller
// Purpose: state enum, opcode/funct constants, ALU control codes and mux select
//          encodings shared by mc_control_fsm and mc_alu_decoder.
// Ports:   none (package).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - controller <-> datapath signal bundle
// Purpose: groups instruction fields, status inputs and all datapath controls.
// Ports (master = controller side):
//   in : op[5:0], funct[5:0], zero, mem_ready
//   out: pcen, irwrite, memwrite, mem_req, iord, regwrite, regdst, memtoreg,
//        alusrca, alusrcb[1:0], alucontrol[2:0], pcsrc[1:0], illegal_op,
//        state_dbg[3:0]
interface mc_control_fsm_if;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       mem_req;
  logic       iord;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, irwrite, memwrite, mem_req, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, alucontrol, pcsrc, illegal_op, state_dbg
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, irwrite, memwrite, mem_req, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, alucontrol, pcsrc, illegal_op, state_dbg
  );

endinterface

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - ALU control decode from FSM aluop and funct field
// Purpose: aluop 00 -> add, 01 -> sub, 10 -> decode funct (unknown -> add).
// Ports:
//   aluop[1:0]      in  operation class from the FSM
//   funct[5:0]      in  instr[5:0]
//   alucontrol[2:0] out ALU operation code
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS main sequencing controller
// Purpose: steps each instruction through FETCH..JUMP and drives datapath
//          enables/selects; memory states stall on mem_ready.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    mc_control_fsm_if.master (op/funct/zero/mem_ready in, controls out)
// Parameter RESET_PC_HOLD: 1 forces all write enables low while rst_n is low.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit RESET_PC_HOLD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mc_control_fsm_if.master      bus
);

  state_t     state, next_state;

  logic       pcwrite;
  logic       branch;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       mem_req_s;
  logic       regwrite_s;
  logic       illegal_s;
  logic       iord_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] aluop;
  logic [1:0] pcsrc_s;
  logic       alu_en;
  logic [2:0] alu_raw;
  logic       hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    mem_req_s  = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    iord_s     = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = SRCB_B;
    aluop      = ALUOP_ADD;
    pcsrc_s    = PCSRC_ALU;
    alu_en     = 1'b1;

    case (state)
      S_FETCH: begin
        mem_req_s = 1'b1;
        alusrcb_s = SRCB_FOUR;
        // Instruction load and PC+4 commit only on the cycle memory delivers.
        irwrite_s = bus.mem_ready;
        pcwrite   = bus.mem_ready;
        if (bus.mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        // Precompute branch target PC + (imm<<2) while decoding.
        alusrcb_s = SRCB_IMM_SH;
        case (bus.op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default: begin
            illegal_s  = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_s  = 1'b1;
        alusrcb_s  = SRCB_IMM;
        next_state = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        if (bus.mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_s  = 1'b1;
        iord_s     = 1'b1;
        memwrite_s = bus.mem_ready;
        if (bus.mem_ready) next_state = S_FETCH;
      end
      S_EXEC: begin
        alusrca_s  = 1'b1;
        aluop      = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_s  = 1'b1;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        pcsrc_s    = PCSRC_ALUOUT;
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_s  = 1'b1;
        alusrcb_s  = SRCB_IMM;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pcwrite    = 1'b1;
        pcsrc_s    = PCSRC_JUMP;
        next_state = S_FETCH;
      end
      default: begin
        // Encodings 12-15: everything quiet, including the ALU code.
        alu_en     = 1'b0;
        next_state = S_FETCH;
      end
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (alu_raw)
  );

  // Reset gating is combinational so enables drop the instant rst_n falls,
  // before the state register has been observed at FETCH by anyone.
  assign hold = RESET_PC_HOLD & ~rst_n;

  assign bus.pcen       = (pcwrite | (branch & bus.zero)) & ~hold;
  assign bus.irwrite    = irwrite_s  & ~hold;
  assign bus.memwrite   = memwrite_s & ~hold;
  assign bus.mem_req    = mem_req_s  & ~hold;
  assign bus.regwrite   = regwrite_s & ~hold;
  assign bus.illegal_op = illegal_s  & ~hold;
  assign bus.iord       = iord_s;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.alucontrol = alu_en ? alu_raw : 3'b000;
  assign bus.pcsrc      = pcsrc_s;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm
module tb_mc_control_fsm;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.RESET_PC_HOLD(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tasks are entered shortly after a falling edge with the FSM in FETCH;
  // outputs are sampled #1 after inputs change, well clear of the rising edge.

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++;
      if (bus.state_dbg !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
      tests++;
      if ({bus.irwrite, bus.pcen, bus.regwrite, bus.mem_req, bus.memwrite} !== 5'b00000) begin
        fails++; $display("FAIL reset_enables: got %b want 00000",
                          {bus.irwrite, bus.pcen, bus.regwrite, bus.mem_req, bus.memwrite});
      end
    end
    tests++;
    if ({bus.alusrcb, bus.alucontrol, bus.iord} !== {2'b01, 3'b010, 1'b0}) begin
      fails++; $display("FAIL reset_fetch_sel: got %b want 010100", {bus.alusrcb, bus.alucontrol, bus.iord});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if ({bus.irwrite, bus.pcen, bus.mem_req} !== 3'b111) begin
      fails++; $display("FAIL release_fetch: got %b want 111", {bus.irwrite, bus.pcen, bus.mem_req});
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_fetch_stall();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      tests++;
      if ({bus.state_dbg, bus.irwrite, bus.pcen, bus.mem_req} !== {4'd0, 3'b001}) begin
        fails++; $display("FAIL fetch_stall: got %b want 0000001",
                          {bus.state_dbg, bus.irwrite, bus.pcen, bus.mem_req});
      end
    end
  endtask

  task automatic test_lw();
    logic [3:0] st [5];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    bus.op = 6'b100011; bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (bus.state_dbg !== st[i]) begin fails++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, bus.state_dbg, st[i]); end
      tests++;
      if (bus.regwrite !== (i == 4)) begin fails++; $display("FAIL lw_regwrite[%0d]: got %b want %b", i, bus.regwrite, (i == 4)); end
      if (i == 4) begin
        tests++;
        if ({bus.memtoreg, bus.regdst} !== 2'b10) begin fails++; $display("FAIL lw_wb_sel: got %b want 10", {bus.memtoreg, bus.regdst}); end
      end
      if (i == 3) begin
        tests++;
        if ({bus.mem_req, bus.iord} !== 2'b11) begin fails++; $display("FAIL lw_memrd: got %b want 11", {bus.mem_req, bus.iord}); end
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if ({bus.state_dbg, bus.regwrite} !== {4'd0, 1'b0}) begin fails++; $display("FAIL lw_done: got %b want 00000", {bus.state_dbg, bus.regwrite}); end
  endtask

  task automatic test_rtype_sub();
    logic [3:0] st [4];
    st = '{4'd0, 4'd1, 4'd6, 4'd7};
    bus.op = 6'b000000; bus.funct = 6'b100010; bus.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (bus.state_dbg !== st[i]) begin fails++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, bus.state_dbg, st[i]); end
      if (i == 2) begin
        tests++;
        if ({bus.alucontrol, bus.alusrca, bus.alusrcb} !== {3'b110, 1'b1, 2'b00}) begin
          fails++; $display("FAIL rtype_exec: got %b want 110100", {bus.alucontrol, bus.alusrca, bus.alusrcb});
        end
      end
      if (i == 3) begin
        tests++;
        if ({bus.regwrite, bus.regdst, bus.memtoreg} !== 3'b110) begin
          fails++; $display("FAIL rtype_wb: got %b want 110", {bus.regwrite, bus.regdst, bus.memtoreg});
        end
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (bus.state_dbg !== 4'd0) begin fails++; $display("FAIL rtype_done: got %0d want 0", bus.state_dbg); end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0] st [3];
    st = '{4'd0, 4'd1, 4'd8};
    bus.op = 6'b000100; bus.zero = z; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.state_dbg !== st[i]) begin fails++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, bus.state_dbg, st[i]); end
      if (i == 2) begin
        tests++;
        if ({bus.pcen, bus.pcsrc, bus.alucontrol} !== {z, 2'b01, 3'b110}) begin
          fails++; $display("FAIL beq_branch(z=%b): got %b want %b", z, {bus.pcen, bus.pcsrc, bus.alucontrol}, {z, 2'b01, 3'b110});
        end
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if (bus.state_dbg !== 4'd0) begin fails++; $display("FAIL beq_done: got %0d want 0", bus.state_dbg); end
    bus.zero = 1'b0;
  endtask

  task automatic test_jump_addi();
    logic [3:0] st [4];
    bus.op = 6'b000010; bus.mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if ({bus.state_dbg, bus.pcen, bus.pcsrc} !== {4'd11, 1'b1, 2'b10}) begin
      fails++; $display("FAIL jump: got %b want 1011110", {bus.state_dbg, bus.pcen, bus.pcsrc});
    end
    @(negedge clk);
    st = '{4'd0, 4'd1, 4'd9, 4'd10};
    bus.op = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (bus.state_dbg !== st[i]) begin fails++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, bus.state_dbg, st[i]); end
      if (i == 3) begin
        tests++;
        if ({bus.regwrite, bus.regdst, bus.memtoreg} !== 3'b100) begin
          fails++; $display("FAIL addi_wb: got %b want 100", {bus.regwrite, bus.regdst, bus.memtoreg});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_stall();
    logic [3:0] st [6];
    logic       mr [6];
    logic       mw [6];
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    mw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.op = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = mr[i];
      #1;
      tests++;
      if ({bus.state_dbg, bus.memwrite} !== {st[i], mw[i]}) begin
        fails++; $display("FAIL sw_cycle[%0d]: got %b want %b", i, {bus.state_dbg, bus.memwrite}, {st[i], mw[i]});
      end
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    #1;
    tests++;
    if ({bus.state_dbg, bus.memwrite} !== {4'd0, 1'b0}) begin
      fails++; $display("FAIL sw_done: got %b want 00000", {bus.state_dbg, bus.memwrite});
    end
  endtask

  task automatic test_illegal();
    bus.op = 6'b111111; bus.mem_ready = 1'b1;
    #1;
    tests++;
    if (bus.illegal_op !== 1'b0) begin fails++; $display("FAIL illegal_fetch: got %b want 0", bus.illegal_op); end
    @(negedge clk); #1;
    tests++;
    if ({bus.state_dbg, bus.illegal_op} !== {4'd1, 1'b1}) begin
      fails++; $display("FAIL illegal_decode: got %b want 00011", {bus.state_dbg, bus.illegal_op});
    end
    @(negedge clk); #1;
    tests++;
    if ({bus.state_dbg, bus.illegal_op} !== {4'd0, 1'b0}) begin
      fails++; $display("FAIL illegal_return: got %b want 00000", {bus.state_dbg, bus.illegal_op});
    end
  endtask

  task automatic test_reset_mid();
    bus.op = 6'b100011; bus.mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if ({bus.state_dbg, bus.regwrite} !== {4'd4, 1'b1}) begin
      fails++; $display("FAIL midrst_pre: got %b want 01001", {bus.state_dbg, bus.regwrite});
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.state_dbg, bus.regwrite, bus.pcen, bus.irwrite, bus.mem_req} !== {4'd0, 4'b0000}) begin
      fails++; $display("FAIL midrst_drop: got %b want 00000000",
                        {bus.state_dbg, bus.regwrite, bus.pcen, bus.irwrite, bus.mem_req});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.op = 6'b000000;
    bus.funct = 6'b100000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_fetch_stall();
    test_lw();
    test_rtype_sub();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump_addi();
    test_sw_stall();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
